// File: rtl/starting_lights_seq.sv
// F1-style starting-lights sequencer: fills N_LEDS lights on divider ticks, then arms the random delay.
// Optional jump-start detection is built when STARTING_LIGHTS_JUMP_START_EN is defined.
module starting_lights_seq #(
  parameter int N_LEDS     = 10,
  parameter int HOLD_TICKS = 1,
  parameter bit FROM_MSB   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              trigger,
  input  logic              timeout,
  input  logic              button,
  output logic              en_lfsr,
  output logic              start_delay,
  output logic [N_LEDS-1:0] ledr,
  output logic              lights_out,
  output logic              jump_start
);

  localparam int SW = $clog2(HOLD_TICKS + 1);
  localparam int LW = $clog2(N_LEDS + 1);

  localparam logic [SW-1:0]     SUB_ZERO = SW'(0);
  localparam logic [SW-1:0]     SUB_ONE  = SW'(1);
  localparam logic [SW-1:0]     SUB_LAST = SW'(HOLD_TICKS - 1);
  localparam logic [LW-1:0]     LIT_ZERO = LW'(0);
  localparam logic [LW-1:0]     LIT_ONE  = LW'(1);
  localparam logic [LW-1:0]     LIT_FULL = LW'(N_LEDS);
  localparam logic [N_LEDS-1:0] LED_OFF  = {N_LEDS{1'b0}};
  localparam logic [N_LEDS-1:0] LED_ALL  = {N_LEDS{1'b1}};

`ifdef STARTING_LIGHTS_JUMP_START_EN
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ARMED = 2'd2, FAULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, ARMED = 2'd2} state_t;
  logic unused_button_s;
  assign unused_button_s = button;
`endif

  state_t          state_r;
  logic [SW-1:0]   sub_r;
  logic [LW-1:0]   lit_r;

  // n ones packed at the LSB end, mirrored to the MSB end when filling downward
  function automatic logic [N_LEDS-1:0] fill_pattern(input logic [LW-1:0] n);
    logic [N_LEDS:0]   mask;
    logic [N_LEDS-1:0] low;
    logic [N_LEDS-1:0] res;
    mask = ({{N_LEDS{1'b0}}, 1'b1} << n) - {{N_LEDS{1'b0}}, 1'b1};
    low  = mask[N_LEDS-1:0];
    res  = low;
    if (FROM_MSB) begin
      for (int i = 0; i < N_LEDS; i++) res[i] = low[N_LEDS-1-i];
    end
    return res;
  endfunction

  // Sequencer state, step counters and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sub_r       <= SUB_ZERO;
      lit_r       <= LIT_ZERO;
      ledr        <= LED_OFF;
      en_lfsr     <= 1'b1;
      start_delay <= 1'b0;
      lights_out  <= 1'b0;
      jump_start  <= 1'b0;
    end else begin
      start_delay <= 1'b0;
      lights_out  <= 1'b0;
      case (state_r)
        IDLE: begin
          ledr    <= LED_OFF;
          en_lfsr <= 1'b1;
          if (tick && trigger) begin
            state_r <= FILL;
            sub_r   <= SUB_ZERO;
            lit_r   <= LIT_ZERO;
          end
        end
        FILL: begin
`ifdef STARTING_LIGHTS_JUMP_START_EN
          if (button) begin
            state_r    <= FAULT;
            jump_start <= 1'b1;
            en_lfsr    <= 1'b1;
            ledr       <= LED_ALL;
          end else
`endif
          if (tick) begin
            if (sub_r == SUB_LAST) begin
              sub_r <= SUB_ZERO;
              lit_r <= lit_r + LIT_ONE;
              ledr  <= fill_pattern(lit_r + LIT_ONE);
              // last light: freeze the LFSR and load the delay counter on the same edge
              if ((lit_r + LIT_ONE) == LIT_FULL) begin
                state_r     <= ARMED;
                start_delay <= 1'b1;
                en_lfsr     <= 1'b0;
              end
            end else begin
              sub_r <= sub_r + SUB_ONE;
            end
          end
        end
        ARMED: begin
          if (timeout) begin
            state_r    <= IDLE;
            ledr       <= LED_OFF;
            lights_out <= 1'b1;
            en_lfsr    <= 1'b1;
          end
`ifdef STARTING_LIGHTS_JUMP_START_EN
          else if (button) begin
            state_r    <= FAULT;
            jump_start <= 1'b1;
            en_lfsr    <= 1'b1;
          end
`endif
        end
`ifdef STARTING_LIGHTS_JUMP_START_EN
        FAULT: begin
          if (tick && trigger) begin
            state_r    <= IDLE;
            jump_start <= 1'b0;
            ledr       <= LED_OFF;
          end else if (tick) begin
            ledr <= ~ledr;
          end
        end
`endif
        default: begin
          state_r <= IDLE;
          ledr    <= LED_OFF;
          en_lfsr <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_starting_lights_seq.sv
// Directed bench for starting_lights_seq: two configurations share stimulus, each checked every
// cycle against a tick-counting model, plus literal expectations at the key steps.
module tb_starting_lights_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tick = 1'b0, trigger = 1'b0, timeout = 1'b0, button = 1'b0;
  logic       a_en, a_sd, a_lo, a_js;
  logic [3:0] a_led;
  logic       b_en, b_sd, b_lo, b_js;
  logic [2:0] b_led;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  starting_lights_seq #(.N_LEDS(4), .HOLD_TICKS(2), .FROM_MSB(1'b1)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .timeout(timeout), .button(button),
    .en_lfsr(a_en), .start_delay(a_sd), .ledr(a_led), .lights_out(a_lo), .jump_start(a_js));

  starting_lights_seq #(.N_LEDS(3), .HOLD_TICKS(1), .FROM_MSB(1'b0)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .timeout(timeout), .button(button),
    .en_lfsr(b_en), .start_delay(b_sd), .ledr(b_led), .lights_out(b_lo), .jump_start(b_js));

  // mode: 0 idle, 1 filling, 2 waiting for timeout, 3 jump-start fault
  typedef struct {
    int          mode;
    int          ticks;
    logic [31:0] led;
    bit          en, sd, lo, js;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mreset();
    mdl_t r;
    r.mode = 0; r.ticks = 0; r.led = 32'd0;
    r.en = 1'b1; r.sd = 1'b0; r.lo = 1'b0; r.js = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] pat(int k, int n, bit msb);
    logic [63:0] v;
    v = (64'd1 << k) - 64'd1;
    if (msb) v = v << (n - k);
    return v[31:0];
  endfunction

  function automatic mdl_t step(mdl_t m, int n, int h, bit msb, bit tk, bit tr, bit to, bit bt);
    mdl_t r = m;
    r.sd = 1'b0;
    r.lo = 1'b0;
    case (m.mode)
      0: begin
        r.led = 32'd0;
        r.en  = 1'b1;
        if (tk && tr) begin r.mode = 1; r.ticks = 0; end
      end
      1: begin
`ifdef STARTING_LIGHTS_JUMP_START_EN
        if (bt) begin r.mode = 3; r.js = 1'b1; r.en = 1'b1; r.led = pat(n, n, msb); end else
`endif
        if (tk) begin
          r.ticks = m.ticks + 1;
          r.led = pat(r.ticks / h, n, msb);
          if (r.ticks == n * h) begin r.mode = 2; r.sd = 1'b1; r.en = 1'b0; end
        end
      end
      2: begin
        if (to) begin r.mode = 0; r.led = 32'd0; r.lo = 1'b1; r.en = 1'b1; end
`ifdef STARTING_LIGHTS_JUMP_START_EN
        else if (bt) begin r.mode = 3; r.js = 1'b1; r.en = 1'b1; end
`endif
      end
      3: begin
        if (tk && tr) begin r.mode = 0; r.js = 1'b0; r.led = 32'd0; end
        else if (tk) r.led = ~m.led & pat(n, n, 1'b0);
      end
      default: r = mreset();
    endcase
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= mreset();
      mb <= mreset();
    end else begin
      ma <= step(ma, 4, 2, 1'b1, tick, trigger, timeout, button);
      mb <= step(mb, 3, 1, 1'b0, tick, trigger, timeout, button);
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_a", {24'd0, a_led, a_en, a_sd, a_lo, a_js},
            {24'd0, ma.led[3:0], ma.en, ma.sd, ma.lo, ma.js});
      check("model_b", {25'd0, b_led, b_en, b_sd, b_lo, b_js},
            {25'd0, mb.led[2:0], mb.en, mb.sd, mb.lo, mb.js});
    end
  end

  task automatic cyc(bit t, bit tr, bit to, bit bt);
    tick = t; trigger = tr; timeout = to; button = bt;
    @(posedge clk);
    #1;
  endtask

  task automatic tk(bit tr);
    cyc(1'b1, tr, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset values
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_ledr", {28'd0, a_led}, 32'h0);
    check("reset_flags", {28'd0, a_en, a_sd, a_lo, a_js}, 32'h8);
    rst = 1'b0;

    // fill from MSB (a) and from LSB (b), then lights out
    tk(1'b1);
    check("t0_ledr", {28'd0, a_led}, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (k == 2) check("fill_2", {28'd0, a_led}, 32'h8);
      if (k == 4) check("fill_4", {28'd0, a_led}, 32'hC);
      if (k == 6) check("fill_6", {28'd0, a_led}, 32'hE);
      if (k == 8) begin
        check("fill_8", {28'd0, a_led}, 32'hF);
        check("armed_sd_en", {30'd0, a_sd, a_en}, 32'h2);
      end
      if (k == 1) check("lsb_1", {29'd0, b_led}, 32'h1);
      if (k == 2) check("lsb_2", {29'd0, b_led}, 32'h3);
      if (k == 3) check("lsb_3", {29'd0, b_led}, 32'h7);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (k == 8) check("sd_one_clk", {31'd0, a_sd}, 32'h0);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("lo_out", {26'd0, a_led, a_lo, a_en}, 32'h3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("lo_clear", {31'd0, a_lo}, 32'h0);

    // ignored inputs: timeout outside ARMED, trigger held through FILL
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k <= 8; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      if (k == 3) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      else        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("ign_armed", {28'd0, a_led}, 32'hF);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    check("exit_tick_trig", {27'd0, a_led, a_lo}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tk(1'b0);
    check("trig_not_taken", {29'd0, b_led}, 32'h0);

    // reset mid-sequence
    tk(1'b1);
    for (int k = 0; k < 4; k++) tk(1'b0);
    check("mid_lit2", {28'd0, a_led}, 32'hC);
    rst = 1'b1;
    #1;
    check("mid_rst", {27'd0, a_led, a_en}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tk(1'b1);
    tk(1'b0);
    tk(1'b0);
    check("restart", {28'd0, a_led}, 32'h8);

    // timeout already high on the ARMED entry edge (b)
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("entry_to_b", {28'd0, b_led, b_lo}, 32'hE);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("exit_b", {28'd0, b_led, b_lo}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) tk(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    check("exit_a", {31'd0, a_lo}, 32'h1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);

`ifdef STARTING_LIGHTS_JUMP_START_EN
    tk(1'b1);
    for (int k = 0; k < 4; k++) tk(1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("js_enter", {27'd0, a_led, a_js}, 32'h1F);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("js_blink0", {28'd0, a_led}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("js_blink1", {28'd0, a_led}, 32'hF);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    check("js_clear", {27'd0, a_led, a_js}, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    tk(1'b1);
    for (int k = 0; k < 8; k++) tk(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check("btn_to_legal", {30'd0, a_lo, a_js}, 32'h2);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/starting_lights_seq.md
# starting_lights_seq

Parametrised F1-style starting-lights sequencer for the reaction-timer experiments. On a trigger it lights `N_LEDS` LEDs one at a time, holding each for `HOLD_TICKS` ticks. Once all are lit it freezes the LFSR and launches the random delay. When the delay times out it blanks the lights and flags "lights out". It sits between the tick divider, the LFSR/delay counter and the LED bank, and optionally detects jump starts.

## Interface
- `N_LEDS`, 10, number of lights, 1..32.
- `HOLD_TICKS`, 1, ticks spent at each lit-count step, >=1.
- `FROM_MSB`, 1, 1: fill from `ledr[N_LEDS-1]` downward; 0: fill from `ledr[0]` upward.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: reset, asynchronous, active-high.
- `tick` in 1: one-`clk`-wide step strobe from the divider.
- `trigger` in 1: start request, sampled only on `tick`.
- `timeout` in 1: random delay expired, sampled every `clk`.
- `button` in 1: reaction button, used only with the macro.
- `en_lfsr` out 1: LFSR run enable.
- `start_delay` out 1: one-`clk` pulse that loads the delay counter.
- `ledr` out N_LEDS: light pattern.
- `lights_out` out 1: one-`clk` pulse when the lights blank.
- `jump_start` out 1: fault flag, always 0 without the macro.

## Operation
- States are IDLE, FILL, ARMED and FAULT. FAULT exists only with the macro.
- Counters:
  - `sub`: width $clog2(HOLD_TICKS+1).
  - `lit`: width $clog2(N_LEDS+1).
  - Both saturate-free and wrap only by explicit clear.
- **IDLE**
  - Outputs: `ledr`=0, `en_lfsr`=1.
  - `tick`&&`trigger` → FILL, with `sub`=0 and `lit`=0.
- **FILL**
  - On each `tick`, `sub` increments.
  - When `sub`==HOLD_TICKS-1 on a `tick`: `sub`←0 and `lit`←`lit`+1.
  - `ledr` shows `lit` ones, packed at the MSB end if `FROM_MSB`, otherwise at the LSB end.
  - When `lit` becomes N_LEDS → ARMED.
- **ARMED**
  - Outputs: `ledr` all ones, `en_lfsr`=0.
  - `timeout`=1 → IDLE, `ledr`←0, and `lights_out` pulses.
- Ignored inputs:
  - `trigger` outside IDLE.
  - `timeout` outside ARMED.
  - `tick` in ARMED.
- All outputs are registered and driven directly from state/counter flops. Outputs are not derived combinationally from inputs.

## Timing
- Reset values:
  - state=IDLE, `ledr`=0, `en_lfsr`=1.
  - `start_delay`=0, `lights_out`=0, `jump_start`=0.
  - `sub`=`lit`=0.
- Reset mid-sequence returns to these values immediately, regardless of `tick`.
- Trigger tick at edge T0: `ledr` stays 0.
- The k-th LED lights on the edge of tick number k·HOLD_TICKS after T0.
- `ledr` reaches all ones N_LEDS·HOLD_TICKS ticks after T0.
- On that same edge:
  - `start_delay` goes high for exactly one `clk`.
  - `en_lfsr` drops to 0.
- Timeout seen high at edge E:
  - `ledr`=0, `lights_out`=1 and `en_lfsr`=1 after E.
  - `lights_out` clears after E+1.
- `timeout` already high on the ARMED entry edge: exit on the next edge, so ARMED lasts a minimum of 1 cycle.
- A `tick` and a `trigger` in the same cycle the sequencer returns to IDLE: the trigger is not taken. The next trigger needs a later tick.
- N_LEDS=1, HOLD_TICKS=1: a single LED lights one tick after the trigger, with `start_delay` on the same edge.

## Configuration
- Macro: `STARTING_LIGHTS_JUMP_START_EN`.
- Defined:
  - `button`=1 in FILL, or in ARMED without `timeout` in the same cycle → FAULT.
  - In FAULT: `jump_start`=1, `en_lfsr`=1, no `start_delay`.
  - `ledr` starts all ones in FAULT and inverts on every `tick`.
  - `tick`&&`trigger` → IDLE and clears `jump_start`.
  - `button` and `timeout` in the same cycle in ARMED is a legal start: `timeout` wins.
- Undefined:
  - `button` is ignored.
  - `jump_start` is constant 0.
  - No FAULT state is synthesised.

## Test plan
- **Reset values:** N_LEDS=4, HOLD_TICKS=2, FROM_MSB=1. Assert `rst`.
  - Expect `ledr`=0000, `en_lfsr`=1 and all pulses 0.
- **Fill and lights out:** same configuration as the reset test. Trigger on tick 0, `timeout` at 3 `clk` after all-on.
  - Expect `ledr` 1000/1100/1110/1111 after ticks 2/4/6/8.
  - Expect `start_delay` for one `clk` at tick 8, with `en_lfsr`=0.
  - After the timeout edge expect `ledr`=0000, a one-`clk` `lights_out` pulse and `en_lfsr`=1.
- **LSB fill:** FROM_MSB=0, N_LEDS=3, HOLD_TICKS=1.
  - Expect `ledr` 001/011/111 on ticks 1/2/3.
- **Ignored inputs:** `trigger` asserted throughout FILL, `timeout` pulsed in IDLE and FILL.
  - Expect the sequence unchanged and no `lights_out`.
- **Reset mid-operation:** `rst` at `lit`=2.
  - Expect `ledr`=0 and IDLE immediately.
  - Expect a fresh trigger to restart from `lit`=0.
- **Jump start (macro on):**
  - `button` at `lit`=2: expect `jump_start`=1, `ledr`=1111 then 0000 on the next tick, alternating, with no `start_delay`.
  - `trigger` tick: expect IDLE and `jump_start`=0.
  - `button`+`timeout` together: expect a normal `lights_out` and no fault.
